// File: rtl/uart_ctrl_rx.sv
// uart_ctrl_rx: 8N1 UART receiver, LSB first, idle-high line.
// Samples each bit at mid-bit time, presents every good byte on data with a
// one-cycle rcv strobe, and flags a low stop bit with a one-cycle ferr strobe.

module uart_ctrl_rx #(
    parameter int unsigned BAUDRATE = 104  // clock cycles per bit, >= 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(BAUDRATE);

    // The counter holds the number of cycles left before the sample point, minus
    // one, so a sample fires exactly BAUDRATE/2 or BAUDRATE cycles after the load.
    localparam logic [CntW-1:0] HalfLoad = CntW'(BAUDRATE / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(BAUDRATE - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntZero  = '0;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Synchronizer and edge-detect flops
    logic rx_meta_q;
    logic rx_s_q;
    logic rx_prev_q;
    logic rx_fall;

    // FSM and datapath state
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic [7:0]      data_q, data_d;
    logic            rcv_q, rcv_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;
    logic            sample;

    // Two-flop synchronizer on rx plus a third flop for falling-edge detection.
    // All reset to 1 so a line held low through reset is not mistaken for idle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;
    assign sample  = (cnt_q == CntZero);

    // Next-state logic: baud counter, bit capture, strobes and busy flag
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != CntZero) ? (cnt_q - CntOne) : cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        rcv_d   = 1'b0;
        ferr_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (rx_fall) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                    busy_d  = 1'b1;
                end
            end

            StStart: begin
                if (sample) begin
                    if (!rx_s_q) begin
                        state_d = StData;
                        idx_d   = 3'd0;
                        cnt_d   = FullLoad;
                    end else begin
                        // Line went back high before mid start bit: false start
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end
                end
            end

            StData: begin
                if (sample) begin
                    shreg_d[idx_q] = rx_s_q;
                    cnt_d          = FullLoad;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end

            StStop: begin
                if (sample) begin
                    if (rx_s_q) begin
                        // Leave mid stop bit so a start bit right after it is caught
                        data_d  = shreg_q;
                        rcv_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end

            StBreak: begin
                // Hold off until the line is released so a break cannot retrigger
                if (rx_s_q) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM, counter and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= CntZero;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            rcv_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            rcv_q   <= rcv_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign data = data_q;
    assign rcv  = rcv_q;
    assign ferr = ferr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_ctrl_rx.sv
// Self-checking bench for uart_ctrl_rx at BAUDRATE=8. Frames are driven
// bit-accurately on rx; a monitor logs every rcv/ferr strobe with its cycle
// number, and each test compares that log against events predicted from the
// frame timing rules (latency from the driven falling edge, byte value).

module tb_uart_ctrl_rx;

    localparam int unsigned B = 8;
    // Pin edge -> rcv/ferr visible: 2 sync cycles + 1 detect + B/2 + 9 bits
    localparam int Lat = 3 + B / 2 + 9 * B;

    logic       clk  = 1'b0;
    logic       rstn = 1'b1;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    always #5 clk = ~clk;

    uart_ctrl_rx #(
        .BAUDRATE(B)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .rx  (rx),
        .data(data),
        .rcv (rcv),
        .ferr(ferr),
        .busy(busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        bit         is_ferr;
    } ev_t;

    int         checks    = 0;
    int         failures  = 0;
    int         cyc       = 0;
    int         overlap   = 0;
    logic [7:0] last_good = 8'h00;
    ev_t        obs[$];
    ev_t        exp_q[$];
    ev_t        mon_e;

    // Strobe monitor: samples 1 time unit after each rising edge
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (rcv === 1'b1 && ferr === 1'b1) overlap = overlap + 1;
        if (rcv === 1'b1 || ferr === 1'b1) begin
            mon_e.cyc     = cyc;
            mon_e.d       = data;
            mon_e.is_ferr = (ferr === 1'b1);
            obs.push_back(mon_e);
        end
    end

    // Drive 'slots' bit periods of a frame (start, 8 data LSB first, stop).
    // Must be called at a falling clock edge; returns at one.
    task automatic drive_frame(input logic [7:0] b, input bit stop, input int slots,
                               output int t_start);
        logic [9:0] bits;
        bits    = {stop, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < slots; i++) begin
            rx = bits[i];
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        #2 rstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h want=00", data);
        end
        checks++;
        if (rcv !== 1'b0) begin
            failures++;
            $display("FAIL reset_rcv got=%b want=0", rcv);
        end
        checks++;
        if (ferr !== 1'b0) begin
            failures++;
            $display("FAIL reset_ferr got=%b want=0", ferr);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        rstn = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        obs.delete();
    endtask

    task automatic test_single_55;
        int t;
        obs.delete();
        drive_frame(8'h55, 1'b1, 10, t);
        idle(2 * B);
        last_good = 8'h55;
        checks++;
        if (obs.size() != 1) begin
            failures++;
            $display("FAIL single55_count got=%0d want=1", obs.size());
        end else begin
            checks++;
            if (obs[0].cyc != t + Lat) begin
                failures++;
                $display("FAIL single55_time got=%0d want=%0d", obs[0].cyc, t + Lat);
            end
            checks++;
            if (obs[0].d !== 8'h55 || obs[0].is_ferr) begin
                failures++;
                $display("FAIL single55_data got=%h ferr=%b want=55 ferr=0",
                         obs[0].d, obs[0].is_ferr);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single55_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_random_frames;
        int         t;
        int         gap;
        logic [7:0] b;
        bit         bad;
        ev_t        e;
        obs.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            drive_frame(b, !bad, 10, t);
            e.cyc     = t + Lat;
            e.is_ferr = bad;
            e.d       = bad ? last_good : b;
            exp_q.push_back(e);
            if (!bad) last_good = b;
            gap = bad ? int'($urandom_range(B, 3 * B)) : int'($urandom_range(0, 2 * B));
            idle(gap);
        end
        idle(3 * B);
        checks++;
        if (obs.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d want=%0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs.size()) begin
                failures++;
                $display("FAIL random_ev%0d missing want cyc=%0d d=%h ferr=%b", i,
                         exp_q[i].cyc, exp_q[i].d, exp_q[i].is_ferr);
            end else if (obs[i].cyc != exp_q[i].cyc || obs[i].d !== exp_q[i].d ||
                         obs[i].is_ferr != exp_q[i].is_ferr) begin
                failures++;
                $display("FAIL random_ev%0d got cyc=%0d d=%h ferr=%b want cyc=%0d d=%h ferr=%b",
                         i, obs[i].cyc, obs[i].d, obs[i].is_ferr,
                         exp_q[i].cyc, exp_q[i].d, exp_q[i].is_ferr);
            end
        end
    endtask

    task automatic test_glitch;
        int t;
        obs.delete();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy_high got=%b want=1", busy);
        end
        idle(3 * B);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy_low got=%b want=0", busy);
        end
        checks++;
        if (obs.size() != 0) begin
            failures++;
            $display("FAIL glitch_strobes got=%0d want=0", obs.size());
        end
        // A good frame right after proves the receiver is back in idle
        obs.delete();
        drive_frame(8'h96, 1'b1, 10, t);
        idle(2 * B);
        last_good = 8'h96;
        checks++;
        if (obs.size() != 1 || obs[0].cyc != t + Lat || obs[0].d !== 8'h96 ||
            obs[0].is_ferr) begin
            failures++;
            $display("FAIL glitch_next_frame got n=%0d want one rcv d=96 at cyc=%0d",
                     obs.size(), t + Lat);
        end
    endtask

    task automatic test_framing_error;
        int         t;
        logic [7:0] prev;
        obs.delete();
        prev = last_good;
        drive_frame(8'hA3, 1'b0, 10, t);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr_busy_held got=%b want=1", busy);
        end
        idle(2 * B);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ferr_busy_release got=%b want=0", busy);
        end
        checks++;
        if (obs.size() != 1) begin
            failures++;
            $display("FAIL ferr_count got=%0d want=1", obs.size());
        end else begin
            checks++;
            if (obs[0].cyc != t + Lat || !obs[0].is_ferr) begin
                failures++;
                $display("FAIL ferr_event got cyc=%0d ferr=%b want cyc=%0d ferr=1",
                         obs[0].cyc, obs[0].is_ferr, t + Lat);
            end
        end
        checks++;
        if (data !== prev) begin
            failures++;
            $display("FAIL ferr_data_kept got=%h want=%h", data, prev);
        end
    endtask

    task automatic test_back_to_back;
        int t0;
        int t1;
        obs.delete();
        drive_frame(8'h00, 1'b1, 10, t0);
        drive_frame(8'hFF, 1'b1, 10, t1);
        idle(2 * B);
        last_good = 8'hFF;
        checks++;
        if (obs.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=2", obs.size());
        end else begin
            checks++;
            if (obs[1].cyc - obs[0].cyc != 10 * B || obs[0].cyc != t0 + Lat) begin
                failures++;
                $display("FAIL b2b_spacing got=%0d,%0d want=%0d,%0d", obs[0].cyc,
                         obs[1].cyc, t0 + Lat, t0 + Lat + 10 * B);
            end
            checks++;
            if (obs[0].d !== 8'h00 || obs[1].d !== 8'hFF || obs[0].is_ferr ||
                obs[1].is_ferr) begin
                failures++;
                $display("FAIL b2b_data got=%h,%h want=00,ff", obs[0].d, obs[1].d);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int         t;
        logic [7:0] b;
        obs.delete();
        b = 8'($urandom);
        drive_frame(b, 1'b1, 5, t);
        rx = b[4];
        repeat (B / 2) @(negedge clk);
        rstn = 1'b0;
        rx   = 1'b1;
        @(negedge clk);
        checks++;
        if (data !== 8'h00 || rcv !== 1'b0 || ferr !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs got d=%h rcv=%b ferr=%b busy=%b want 00 0 0 0",
                     data, rcv, ferr, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        last_good = 8'h00;
        idle(2 * B);
        checks++;
        if (obs.size() != 0) begin
            failures++;
            $display("FAIL midreset_strobes got=%0d want=0", obs.size());
        end
        obs.delete();
        drive_frame(8'h3C, 1'b1, 10, t);
        idle(2 * B);
        last_good = 8'h3C;
        checks++;
        if (obs.size() != 1 || obs[0].cyc != t + Lat || obs[0].d !== 8'h3C ||
            obs[0].is_ferr) begin
            failures++;
            $display("FAIL midreset_next_frame got n=%0d want one rcv d=3c at cyc=%0d",
                     obs.size(), t + Lat);
        end
    endtask

    task automatic test_no_overlap;
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL rcv_ferr_overlap got=%0d want=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_single_55();
        test_random_frames();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
